// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore FSM sequencing RV32I instructions through fetch, decode, execute,
//   memory and write-back over a shared instruction/data memory.
//
// Parameters
//   ENABLE_UPPER : 1 = LUI/AUIPC legal, 0 = they trap as illegal opcodes
//   MEM_TIMEOUT  : max cycles a memory state waits for mem_ready (0 = no limit)
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   opcode[6:0]            : instruction register bits [6:0]
//   mem_ready              : memory completes the current request this cycle
//   mem_req, mem_we, iord  : memory request / write enable / addr select (1 = ALUOut)
//   ir_write, pc_write     : IR / PC load enables
//   pc_write_cond          : branch PC load, gated by the datapath compare
//   reg_write              : register file write enable
//   pc_src                 : 0 = ALU result, 1 = ALUOut
//   alu_src_a[1:0]         : 00 PC, 01 old PC, 10 rs1, 11 zero
//   alu_src_b[1:0]         : 00 rs2, 01 imm, 10 constant 4
//   alu_op[1:0]            : 00 add, 01 branch compare, 10 funct-decoded
//   result_src[1:0]        : 00 ALUOut, 01 memory data, 10 ALU result
//   instr_retired          : one-cycle pulse on the last cycle of an instruction
//   trap, trap_cause[1:0]  : sticky fault, 01 illegal opcode, 10 memory timeout
//   state[3:0]             : current FSM state (debug)
module multicycle_control_unit #(
  parameter bit ENABLE_UPPER = 1'b1,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE  = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4, S_MADDR = 4'd5,  S_MEM_RD = 4'd6,  S_MEM_WR = 4'd7;
  localparam logic [3:0] S_MEM_WB = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_JAL   = 4'd11;
  localparam logic [3:0] S_EXJALR = 4'd12, S_JALR_WB = 4'd13, S_UPPER = 4'd14, S_TRAP = 4'd15;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // Counter sized to hold MEM_TIMEOUT; a disabled timeout still needs a 1-bit counter.
  localparam int          CW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit          TMO_EN = (MEM_TIMEOUT > 0);

  logic [3:0]    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;
  logic          w_mem_st, w_wait, w_tmo;

  assign w_mem_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_wait   = w_mem_st && !mem_ready;
  // r_cnt counts completed wait cycles, so it equals MEM_TIMEOUT-1 on the
  // MEM_TIMEOUT-th cycle in the state; a late mem_ready still wins.
  assign w_tmo    = TMO_EN && w_wait && (r_cnt == C_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = w_tmo ? S_TRAP : (mem_ready ? S_DECODE : S_FETCH);
      S_DECODE: begin
        unique case (opcode)
          OP_R:             w_next = S_EXEC_R;
          OP_I:             w_next = S_EXEC_I;
          OP_LD, OP_ST:     w_next = S_MADDR;
          OP_BR:            w_next = S_BRANCH;
          OP_JAL:           w_next = S_JAL;
          OP_JALR:          w_next = S_EXJALR;
          OP_LUI, OP_AUIPC: w_next = ENABLE_UPPER ? S_UPPER : S_TRAP;
          default:          w_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_UPPER: w_next = S_ALU_WB;
      S_MADDR:  w_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: w_next = w_tmo ? S_TRAP : (mem_ready ? S_MEM_WB : S_MEM_RD);
      S_MEM_WR: w_next = w_tmo ? S_TRAP : (mem_ready ? S_FETCH : S_MEM_WR);
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_WB: w_next = S_FETCH;
      S_EXJALR: w_next = S_JALR_WB;
      default:  w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      // Count only while stalled in the same memory state; any exit clears,
      // so each entry to FETCH/MEM_RD/MEM_WR starts from zero. Saturates.
      if (w_wait && !w_tmo && (r_cnt != '1))
        r_cnt <= r_cnt + CW'(1);
      else if (!w_wait)
        r_cnt <= '0;
      if ((r_state != S_TRAP) && (w_next == S_TRAP))
        r_cause <= w_tmo ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    instr_retired = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_MADDR, S_EXJALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        iord          = 1'b1;
        instr_retired = mem_ready;
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        result_src    = 2'b01;
        instr_retired = 1'b1;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
      end
      S_JAL, S_JALR_WB: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b10;
        reg_write     = 1'b1;
        result_src    = 2'b10;
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
      end
      S_UPPER: begin
        // LUI adds imm to zero, AUIPC adds imm to the old PC.
        alu_src_a = opcode[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
  end

  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4, S_MADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7;
  localparam logic [3:0] S_MEM_WB = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11;
  localparam logic [3:0] S_EXJALR = 4'd12, S_JALR_WB = 4'd13, S_UPPER = 4'd14, S_TRAP = 4'd15;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // {req, we, iord, irw, pcw, pwc, rw, psrc, a, b, op, rs, retire}
  localparam logic [16:0] C_ZERO = 17'b0_0_0_0_0_0_0_0_00_00_00_00_0;
  localparam logic [16:0] C_FET  = 17'b1_0_0_1_1_0_0_0_00_10_00_00_0;
  localparam logic [16:0] C_FETW = 17'b1_0_0_0_0_0_0_0_00_10_00_00_0;
  localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_01_01_00_00_0;
  localparam logic [16:0] C_EXR  = 17'b0_0_0_0_0_0_0_0_10_00_10_00_0;
  localparam logic [16:0] C_EXI  = 17'b0_0_0_0_0_0_0_0_10_01_10_00_0;
  localparam logic [16:0] C_MA   = 17'b0_0_0_0_0_0_0_0_10_01_00_00_0;
  localparam logic [16:0] C_MRD  = 17'b1_0_1_0_0_0_0_0_00_00_00_00_0;
  localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_1_0_00_00_00_01_1;
  localparam logic [16:0] C_MWR  = 17'b1_1_1_0_0_0_0_0_00_00_00_00_1;
  localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_1_0_00_00_00_00_1;
  localparam logic [16:0] C_BR   = 17'b0_0_0_0_0_1_0_1_10_00_01_00_1;
  localparam logic [16:0] C_JAL  = 17'b0_0_0_0_1_0_1_1_01_10_00_10_1;
  localparam logic [16:0] C_LUI  = 17'b0_0_0_0_0_0_0_0_11_01_00_00_0;
  localparam logic [16:0] C_AUI  = 17'b0_0_0_0_0_0_0_0_01_01_00_00_0;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rdy_a, rdy_b;
  logic [6:0] op_a, op_b;

  logic       req_a, we_a, iord_a, irw_a, pcw_a, pwc_a, rw_a, psrc_a, ret_a, trap_a;
  logic [1:0] sa_a, sb_a, aop_a, rs_a, cause_a;
  logic [3:0] st_a;
  logic       req_b, we_b, iord_b, irw_b, pcw_b, pwc_b, rw_b, psrc_b, ret_b, trap_b;
  logic [1:0] sa_b, sb_b, aop_b, rs_b, cause_b;
  logic [3:0] st_b;
  logic [16:0] ctl_a, ctl_b;

  assign ctl_a = {req_a, we_a, iord_a, irw_a, pcw_a, pwc_a, rw_a, psrc_a, sa_a, sb_a, aop_a, rs_a, ret_a};
  assign ctl_b = {req_b, we_b, iord_b, irw_b, pcw_b, pwc_b, rw_b, psrc_b, sa_b, sb_b, aop_b, rs_b, ret_b};

  always #5 clk = ~clk;

  multicycle_control_unit #(.ENABLE_UPPER(1'b1), .MEM_TIMEOUT(16)) u_a (
    .clk(clk), .rst_n(rst_a), .opcode(op_a), .mem_ready(rdy_a),
    .mem_req(req_a), .mem_we(we_a), .iord(iord_a), .ir_write(irw_a), .pc_write(pcw_a),
    .pc_write_cond(pwc_a), .reg_write(rw_a), .pc_src(psrc_a), .alu_src_a(sa_a),
    .alu_src_b(sb_a), .alu_op(aop_a), .result_src(rs_a), .instr_retired(ret_a),
    .trap(trap_a), .trap_cause(cause_a), .state(st_a));

  multicycle_control_unit #(.ENABLE_UPPER(1'b0), .MEM_TIMEOUT(4)) u_b (
    .clk(clk), .rst_n(rst_b), .opcode(op_b), .mem_ready(rdy_b),
    .mem_req(req_b), .mem_we(we_b), .iord(iord_b), .ir_write(irw_b), .pc_write(pcw_b),
    .pc_write_cond(pwc_b), .reg_write(rw_b), .pc_src(psrc_b), .alu_src_a(sa_b),
    .alu_src_b(sb_b), .alu_op(aop_b), .result_src(rs_b), .instr_retired(ret_b),
    .trap(trap_b), .trap_cause(cause_b), .state(st_b));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply inputs for one cycle (at the falling edge), check state and the
  // control vector, then advance to the next falling edge.
  task automatic vec(input bit b, input string tag, input logic [3:0] st,
                     input logic [6:0] op, input logic rdy, input logic [16:0] ctl);
    if (b) begin op_b = op; rdy_b = rdy; end
    else   begin op_a = op; rdy_a = rdy; end
    #1;
    chk({tag, "/st"},  b ? st_b  : st_a,  st);
    chk({tag, "/ctl"}, b ? ctl_b : ctl_a, ctl);
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0;
    op_a = 7'd0;  op_b = 7'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_a/st", st_a, S_IDLE);
    chk("rst_a/ctl", ctl_a, C_ZERO);
    chk("rst_a/trap", {trap_a, cause_a}, 3'b000);
    rst_a = 1'b1;
    @(negedge clk);

    // add, lw, sw, beq, jal with zero wait states: retire at 4, 9, 13, 16, 19
    vec(0, "add", S_FETCH,  OP_R,  1, C_FET);
    vec(0, "add", S_DECODE, OP_R,  1, C_DEC);
    vec(0, "add", S_EXEC_R, OP_R,  1, C_EXR);
    vec(0, "add", S_ALU_WB, OP_R,  1, C_AWB);
    vec(0, "lw",  S_FETCH,  OP_LD, 1, C_FET);
    vec(0, "lw",  S_DECODE, OP_LD, 1, C_DEC);
    vec(0, "lw",  S_MADDR,  OP_LD, 1, C_MA);
    vec(0, "lw",  S_MEM_RD, OP_LD, 1, C_MRD);
    vec(0, "lw",  S_MEM_WB, OP_LD, 1, C_MWB);
    vec(0, "sw",  S_FETCH,  OP_ST, 1, C_FET);
    vec(0, "sw",  S_DECODE, OP_ST, 1, C_DEC);
    vec(0, "sw",  S_MADDR,  OP_ST, 1, C_MA);
    vec(0, "sw",  S_MEM_WR, OP_ST, 1, C_MWR);
    vec(0, "beq", S_FETCH,  OP_BR, 1, C_FET);
    vec(0, "beq", S_DECODE, OP_BR, 1, C_DEC);
    vec(0, "beq", S_BRANCH, OP_BR, 1, C_BR);
    vec(0, "jal", S_FETCH,  OP_JAL, 1, C_FET);
    vec(0, "jal", S_DECODE, OP_JAL, 1, C_DEC);
    vec(0, "jal", S_JAL,    OP_JAL, 1, C_JAL);

    // lw with 3 wait cycles in MEM_RD: retire at cycle 8
    vec(0, "lw3", S_FETCH,  OP_LD, 1, C_FET);
    vec(0, "lw3", S_DECODE, OP_LD, 1, C_DEC);
    vec(0, "lw3", S_MADDR,  OP_LD, 1, C_MA);
    vec(0, "lw3", S_MEM_RD, OP_LD, 0, C_MRD);
    vec(0, "lw3", S_MEM_RD, OP_LD, 0, C_MRD);
    vec(0, "lw3", S_MEM_RD, OP_LD, 0, C_MRD);
    vec(0, "lw3", S_MEM_RD, OP_LD, 1, C_MRD);
    vec(0, "lw3", S_MEM_WB, OP_LD, 1, C_MWB);

    vec(0, "addi", S_FETCH,  OP_I, 1, C_FET);
    vec(0, "addi", S_DECODE, OP_I, 1, C_DEC);
    vec(0, "addi", S_EXEC_I, OP_I, 1, C_EXI);
    vec(0, "addi", S_ALU_WB, OP_I, 1, C_AWB);

    vec(0, "jalr", S_FETCH,   OP_JALR, 1, C_FET);
    vec(0, "jalr", S_DECODE,  OP_JALR, 1, C_DEC);
    vec(0, "jalr", S_EXJALR,  OP_JALR, 1, C_MA);
    vec(0, "jalr", S_JALR_WB, OP_JALR, 1, C_JAL);

    vec(0, "lui", S_FETCH,  OP_LUI, 1, C_FET);
    vec(0, "lui", S_DECODE, OP_LUI, 1, C_DEC);
    vec(0, "lui", S_UPPER,  OP_LUI, 1, C_LUI);
    vec(0, "lui", S_ALU_WB, OP_LUI, 1, C_AWB);

    vec(0, "auipc", S_FETCH,  OP_AUIPC, 1, C_FET);
    vec(0, "auipc", S_DECODE, OP_AUIPC, 1, C_DEC);
    vec(0, "auipc", S_UPPER,  OP_AUIPC, 1, C_AUI);
    vec(0, "auipc", S_ALU_WB, OP_AUIPC, 1, C_AWB);

    // Asynchronous reset in the middle of a stalled MEM_RD
    vec(0, "rstmid", S_FETCH,  OP_LD, 1, C_FET);
    vec(0, "rstmid", S_DECODE, OP_LD, 1, C_DEC);
    vec(0, "rstmid", S_MADDR,  OP_LD, 1, C_MA);
    rdy_a = 1'b0;
    #1;
    chk("rstmid/req_before", req_a, 1'b1);
    rst_a = 1'b0;
    #1;
    chk("rstmid/req_after", req_a, 1'b0);
    chk("rstmid/st", st_a, S_IDLE);
    chk("rstmid/ctl", ctl_a, C_ZERO);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("rstmid/st_rel", st_a, S_IDLE);
    @(negedge clk);
    chk("rstmid/st_fetch", st_a, S_FETCH);

    // u_b: ENABLE_UPPER=0, MEM_TIMEOUT=4, held in reset until now
    chk("rst_b/st", st_b, S_IDLE);
    chk("rst_b/trap", {trap_b, cause_b}, 3'b000);
    rst_b = 1'b1;
    @(negedge clk);
    vec(1, "tmo", S_FETCH, OP_LUI, 0, C_FETW);
    vec(1, "tmo", S_FETCH, OP_LUI, 0, C_FETW);
    vec(1, "tmo", S_FETCH, OP_LUI, 0, C_FETW);
    vec(1, "tmo", S_FETCH, OP_LUI, 0, C_FETW);
    vec(1, "tmo", S_TRAP,  OP_LUI, 0, C_ZERO);
    chk("tmo/trap", {trap_b, cause_b}, 3'b110);
    vec(1, "tmo_sticky", S_TRAP, OP_LUI, 1, C_ZERO);
    chk("tmo_sticky/trap", {trap_b, cause_b}, 3'b110);

    rst_b = 1'b0;
    #1;
    chk("rst_b2/trap", {trap_b, cause_b}, 3'b000);
    chk("rst_b2/st", st_b, S_IDLE);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    // Ready on the 4th FETCH cycle wins over the timeout
    vec(1, "late", S_FETCH,  OP_LUI, 0, C_FETW);
    vec(1, "late", S_FETCH,  OP_LUI, 0, C_FETW);
    vec(1, "late", S_FETCH,  OP_LUI, 0, C_FETW);
    vec(1, "late", S_FETCH,  OP_LUI, 1, C_FET);
    vec(1, "late", S_DECODE, OP_LUI, 1, C_DEC);
    // LUI with ENABLE_UPPER=0 is illegal
    vec(1, "illegal", S_TRAP, OP_LUI, 1, C_ZERO);
    chk("illegal/trap", {trap_b, cause_b}, 3'b101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
